forward_ctrl: RTL and testbench

Operand-forwarding and load-use interlock controller for the five-stage pipeline. Tracks the destination registers of instructions in EX, MEM, WB and one post-WB slot, and produces the registered 2-bit select codes that drive the two EX-stage 4:1 operand multiplexers. Raises a one-cycle stall when an ID-stage instruction needs a load result that is not yet available.

---
 rtl/pcpu_pkg.sv | 26 ++
 rtl/fwd_sel.sv | 46 ++++
 rtl/forward_ctrl.sv | 98 +++++++++
 tb/tb_forward_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcpu_pkg                                                             |
// | Shared pipeline types: forwarding select codes and tracker slot.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pcpu_pkg;

    localparam int RD_W = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;
    localparam logic [1:0] FWD_WB2 = 2'd3;

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic [RD_W-1:0] rd;
        logic            load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_sel                                                              |
// | Priority compare of one source register against EX/MEM/WB slots.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fwd_sel
    import pcpu_pkg::*;
#(
    parameter int REG_AW = RD_W
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_used,
    input  slot_t             ex_slot,
    input  slot_t             mem_slot,
    input  slot_t             wb_slot,
    output logic [1:0]        code,
    output logic              load_hit
);

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;
    logic w_src_ok;

    // r0 is hard-wired to zero, so it never forwards.
    assign w_src_ok  = src_used && (src != '0);
    assign w_hit_ex  = w_src_ok && ex_slot.valid  && ex_slot.wen  && (ex_slot.rd  == src);
    assign w_hit_mem = w_src_ok && mem_slot.valid && mem_slot.wen && (mem_slot.rd == src);
    assign w_hit_wb  = w_src_ok && wb_slot.valid  && wb_slot.wen  && (wb_slot.rd  == src);

    always_comb begin
        code = FWD_RF;
        if (w_hit_ex) begin
            code = FWD_MEM;
        end else if (w_hit_mem) begin
            code = FWD_WB;
        end else if (w_hit_wb) begin
            code = FWD_WB2;
        end
    end

    assign load_hit = w_hit_ex && ex_slot.load;

endmodule
`default_nettype wire

// File: rtl/forward_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | forward_ctrl                                                         |
// | Operand-forward select registers and load-use interlock.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module forward_ctrl
    import pcpu_pkg::*;
#(
    parameter int REG_AW = RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_en,
    input  logic              flush,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_load,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall
);

    slot_t      r_ex;
    slot_t      r_mem;
    slot_t      r_wb;
    slot_t      r_wb2;
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    logic [1:0] w_code_a;
    logic [1:0] w_code_b;
    logic       w_lhit_a;
    logic       w_lhit_b;
    logic       w_stall;
    logic       w_bubble;
    slot_t      w_id_slot;

    fwd_sel #(.REG_AW(REG_AW)) u_sel_a (
        .src      (id_rs),
        .src_used (id_use_rs),
        .ex_slot  (r_ex),
        .mem_slot (r_mem),
        .wb_slot  (r_wb),
        .code     (w_code_a),
        .load_hit (w_lhit_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_sel_b (
        .src      (id_rt),
        .src_used (id_use_rt),
        .ex_slot  (r_ex),
        .mem_slot (r_mem),
        .wb_slot  (r_wb),
        .code     (w_code_b),
        .load_hit (w_lhit_b)
    );

    // A killed ID instruction cannot cause a hazard.
    assign w_stall  = (w_lhit_a || w_lhit_b) && !flush;
    assign w_bubble = w_stall || flush;

    always_comb begin
        w_id_slot       = SLOT_EMPTY;
        w_id_slot.valid = 1'b1;
        w_id_slot.wen   = id_wen;
        w_id_slot.rd    = id_rd;
        w_id_slot.load  = id_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex    <= SLOT_EMPTY;
            r_mem   <= SLOT_EMPTY;
            r_wb    <= SLOT_EMPTY;
            r_wb2   <= SLOT_EMPTY;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (pipe_en) begin
            r_wb2   <= r_wb;
            r_wb    <= r_mem;
            r_mem   <= r_ex;
            r_ex    <= w_bubble ? SLOT_EMPTY : w_id_slot;
            r_fwd_a <= w_bubble ? FWD_RF : w_code_a;
            r_fwd_b <= w_bubble ? FWD_RF : w_code_b;
        end
    end

    assign fwd_a = r_fwd_a;
    assign fwd_b = r_fwd_b;
    assign stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_forward_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_forward_ctrl                                                      |
// | Table-driven directed bench for the forwarding/interlock controller. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_forward_ctrl;

    logic       clk;
    logic       rst;
    logic       pipe_en;
    logic       flush;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_rd;
    logic       id_wen;
    logic       id_load;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;

    int n_cmp;
    int n_bad;

    typedef struct {
        int rst;
        int en;
        int fl;
        int rs;
        int rt;
        int urs;
        int urt;
        int rd;
        int wen;
        int ld;
        int exp_stall;
        int exp_a;
        int exp_b;
    } vec_t;

    vec_t vq[$];

    forward_ctrl #(.REG_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_en   (pipe_en),
        .flush     (flush),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_rd     (id_rd),
        .id_wen    (id_wen),
        .id_load   (id_load),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int r, input int e, input int f, input int rs_i, input int rt_i,
                       input int urs, input int urt, input int rd_i, input int w, input int l,
                       input int es, input int ea, input int eb);
        vec_t v;
        v = '{r, e, f, rs_i, rt_i, urs, urt, rd_i, w, l, es, ea, eb};
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        pipe_en   = 1'b1;
        flush     = 1'b0;
        id_rs     = '0;
        id_rt     = '0;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        id_rd     = '0;
        id_wen    = 1'b0;
        id_load   = 1'b0;

        //   rst en fl rs rt urs urt rd wen ld   stall a b
        add(0, 1, 0,  3, 0, 1, 0,  0, 0, 0,   0, 0, 0);  // 0 no producers
        add(0, 1, 0,  0, 0, 0, 0,  5, 1, 0,   0, 0, 0);  // 1 I1 rd5
        add(0, 1, 0,  5, 5, 1, 1,  6, 1, 0,   0, 1, 1);  // 2 I2 reads r5
        add(0, 1, 0,  5, 6, 1, 1,  0, 0, 0,   0, 2, 1);  // 3 I3
        add(0, 1, 0,  5, 6, 1, 1,  0, 0, 0,   0, 3, 2);  // 4 I4
        add(0, 1, 0,  5, 6, 1, 1,  0, 0, 0,   0, 0, 3);  // 5 I5
        add(0, 1, 0,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0);  // 6 nop
        add(0, 1, 0,  0, 0, 0, 0,  8, 1, 1,   0, 0, 0);  // 7 LW r8
        add(0, 1, 0,  2, 8, 1, 1,  9, 1, 0,   1, 0, 0);  // 8 ADD rt=8 stalls
        add(0, 1, 0,  2, 8, 1, 1,  9, 1, 0,   0, 0, 2);  // 9 retry
        add(0, 1, 0,  0, 0, 0, 0,  0, 1, 1,   0, 0, 0);  // 10 LW r0
        add(0, 1, 0,  0, 0, 1, 1,  0, 0, 0,   0, 0, 0);  // 11 reads r0
        add(0, 1, 0,  0, 0, 0, 0,  8, 1, 1,   0, 0, 0);  // 12 LW r8
        add(0, 1, 1,  8, 0, 1, 0, 10, 1, 0,   0, 0, 0);  // 13 ADD + flush
        add(0, 1, 0,  8, 0, 1, 0,  0, 0, 0,   0, 2, 0);  // 14 no EX producer
        add(0, 1, 0,  0, 0, 0, 0, 11, 1, 0,   0, 0, 0);  // 15 P1 rd11
        add(0, 1, 0, 11,11, 1, 1, 12, 1, 0,   0, 1, 1);  // 16 P2 rd12
        add(0, 0, 0, 12,11, 1, 1,  0, 0, 0,   0, 1, 1);  // 17 freeze
        add(0, 0, 0, 12,11, 1, 1,  0, 0, 0,   0, 1, 1);  // 18 freeze
        add(0, 0, 0, 12,11, 1, 1,  0, 0, 0,   0, 1, 1);  // 19 freeze
        add(0, 1, 0, 12,11, 1, 1,  0, 0, 0,   0, 1, 2);  // 20 P3 resumes
        add(0, 1, 0, 11,12, 1, 1,  0, 0, 0,   0, 3, 2);  // 21 P4
        add(0, 1, 0,  0, 0, 0, 0, 13, 1, 1,   0, 0, 0);  // 22 LW r13
        add(0, 0, 0, 13, 0, 1, 0,  0, 0, 0,   1, 0, 0);  // 23 frozen hazard
        add(0, 1, 0, 13, 0, 1, 0,  0, 0, 0,   1, 0, 0);  // 24 stall takes effect
        add(0, 1, 0, 13, 0, 1, 0,  0, 0, 0,   0, 2, 0);  // 25 retry
        add(0, 1, 0,  0, 0, 0, 0, 14, 1, 0,   0, 0, 0);  // 26 ALU r14
        add(0, 1, 0,  0, 0, 0, 0, 15, 1, 1,   0, 0, 0);  // 27 LW r15
        add(0, 1, 0, 15,14, 1, 1,  0, 0, 0,   1, 0, 0);  // 28 double hazard
        add(0, 1, 0, 15,14, 1, 1,  0, 0, 0,   0, 2, 3);  // 29 retry
        add(0, 1, 0,  0, 0, 0, 0, 16, 1, 0,   0, 0, 0);  // 30 r16
        add(0, 1, 0,  0, 0, 0, 0, 16, 1, 0,   0, 0, 0);  // 31 r16
        add(0, 1, 0,  0, 0, 0, 0, 16, 1, 0,   0, 0, 0);  // 32 r16
        add(0, 1, 0, 16,16, 1, 0,  0, 0, 0,   0, 1, 0);  // 33 EX wins, rt unused
        add(1, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0);  // 34 reset during freeze
        add(0, 1, 0, 16,16, 1, 1,  0, 0, 0,   0, 0, 0);  // 35 slots cleared

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_fwd_a", -1, int'(fwd_a), 0);
        check("reset_fwd_b", -1, int'(fwd_b), 0);
        check("reset_stall", -1, int'(stall), 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst       = 1'(vq[i].rst);
            pipe_en   = 1'(vq[i].en);
            flush     = 1'(vq[i].fl);
            id_rs     = 5'(vq[i].rs);
            id_rt     = 5'(vq[i].rt);
            id_use_rs = 1'(vq[i].urs);
            id_use_rt = 1'(vq[i].urt);
            id_rd     = 5'(vq[i].rd);
            id_wen    = 1'(vq[i].wen);
            id_load   = 1'(vq[i].ld);
            @(negedge clk);
            check("stall", i, int'(stall), vq[i].exp_stall);
            @(posedge clk);
            #1;
            check("fwd_a", i, int'(fwd_a), vq[i].exp_a);
            check("fwd_b", i, int'(fwd_b), vq[i].exp_b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
